// File: rtl/demorgan_sweep_checker.sv
// Sweeps a two-input De Morgan gate through {A,B}=00..11 and checks nA, nB, nAandnB.
// Optional macro DEMORGAN_CHK_HALT_EN: stop the sweep at the first mismatching vector.
module demorgan_sweep_checker #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       A,
   output logic       B,
   input  logic       nA,
   input  logic       nB,
   input  logic       nAandnB,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic [3:0] fail_vec
);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);

   state_t     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] err_q, err_d;
   logic [3:0] fail_q, fail_d;
   logic       pass_q, pass_d;

   logic [2:0] mism;
   logic [1:0] mism_cnt;
   logic [3:0] err_sum;
   logic       halt;

   always_comb begin
      mism     = {nA ^ ~idx_q[1], nB ^ ~idx_q[0], nAandnB ^ (~idx_q[1] & ~idx_q[0])};
      mism_cnt = {1'b0, mism[0]} + {1'b0, mism[1]} + {1'b0, mism[2]};
      err_sum  = err_q + {2'b00, mism_cnt};
`ifdef DEMORGAN_CHK_HALT_EN
      halt     = |mism;
`else
      halt     = 1'b0;
`endif
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      fail_d  = fail_q;
      pass_d  = pass_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               err_d   = 4'd0;
               fail_d  = 4'd0;
               pass_d  = 1'b0;
               idx_d   = 2'd0;
               cnt_d   = CNT_RELOAD;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt_q == 4'd0) state_d = SAMPLE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         SAMPLE: begin
            err_d = err_sum;
            if (|mism) fail_d[idx_q] = 1'b1;
            // pass is resolved here so it is already valid during the done cycle
            if (idx_q == 2'd3 || halt) begin
               idx_d   = 2'd0;
               pass_d  = (err_sum == 4'd0);
               state_d = DONE;
            end else begin
               idx_d   = idx_q + 2'd1;
               cnt_d   = CNT_RELOAD;
               state_d = SETTLE;
            end
         end
         DONE: begin
            idx_d   = 2'd0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= 2'd0;
         cnt_q   <= 4'd0;
         err_q   <= 4'd0;
         fail_q  <= 4'd0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         fail_q  <= fail_d;
         pass_q  <= pass_d;
      end
   end

   assign A         = idx_q[1];
   assign B         = idx_q[0];
   assign busy      = (state_q == SETTLE) || (state_q == SAMPLE);
   assign done      = (state_q == DONE);
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_vec  = fail_q;

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// Scoreboard bench: three checkers (settle 2/1/3) driving direct and 3-clock-delayed gate models.
module tb_demorgan_sweep_checker;

   typedef struct {
      logic       p;
      logic [3:0] e;
      logic [3:0] f;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic [1:0] mode = 2'd0;

   logic A2, B2, busy2, done2, pass2;
   logic [3:0] err2, fail2;
   logic g2_na, g2_nb, g2_nab;
   logic A1, B1, busy1, done1, pass1;
   logic [3:0] err1, fail1;
   logic A3, B3, busy3, done3, pass3;
   logic [3:0] err3, fail3;
   logic [1:0] p1 [3];
   logic [1:0] p3 [3];

   int checks = 0;
   int errors = 0;
   exp_t q2[$];
   exp_t q3[$];
   logic q1[$];

   always #5 clk = ~clk;

   demorgan_sweep_checker #(.SETTLE_CYCLES(2)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start), .A(A2), .B(B2),
      .nA(g2_na), .nB(g2_nb), .nAandnB(g2_nab), .busy(busy2), .done(done2),
      .pass(pass2), .err_count(err2), .fail_vec(fail2));

   demorgan_sweep_checker #(.SETTLE_CYCLES(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start), .A(A1), .B(B1),
      .nA(~p1[2][1]), .nB(~p1[2][0]), .nAandnB(~p1[2][1] & ~p1[2][0]),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fail1));

   demorgan_sweep_checker #(.SETTLE_CYCLES(3)) u3 (
      .clk(clk), .rst_n(rst_n), .start(start), .A(A3), .B(B3),
      .nA(~p3[2][1]), .nB(~p3[2][0]), .nAandnB(~p3[2][1] & ~p3[2][0]),
      .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .fail_vec(fail3));

   // mode 0 correct, 1 nAandnB stuck 0, 2 OR instead of AND, 3 nA stuck 0
   always_comb begin
      g2_na  = ~A2;
      g2_nb  = ~B2;
      g2_nab = ~A2 & ~B2;
      case (mode)
         2'd1: g2_nab = 1'b0;
         2'd2: g2_nab = g2_na | g2_nb;
         2'd3: g2_na  = 1'b0;
         default: ;
      endcase
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            p1[i] <= 2'd0;
            p3[i] <= 2'd0;
         end
      end else begin
         p1[0] <= {A1, B1}; p1[1] <= p1[0]; p1[2] <= p1[1];
         p3[0] <= {A3, B3}; p3[1] <= p3[0]; p3[2] <= p3[1];
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t x;
      if (done2) begin
         if (q2.size() == 0) check("u2_unexpected_done", 16'd1, 16'd0);
         else begin
            x = q2.pop_front();
            check("u2_pass", {15'd0, pass2}, {15'd0, x.p});
            check("u2_err_count", {12'd0, err2}, {12'd0, x.e});
            check("u2_fail_vec", {12'd0, fail2}, {12'd0, x.f});
         end
      end
      if (done1) begin
         if (q1.size() == 0) check("u1_unexpected_done", 16'd1, 16'd0);
         else check("u1_pass", {15'd0, pass1}, {15'd0, q1.pop_front()});
      end
      if (done3) begin
         if (q3.size() == 0) check("u3_unexpected_done", 16'd1, 16'd0);
         else begin
            x = q3.pop_front();
            check("u3_pass", {15'd0, pass3}, {15'd0, x.p});
            check("u3_err_count", {12'd0, err3}, {12'd0, x.e});
         end
      end
   end

   task automatic push(input logic p, input logic [3:0] e, input logic [3:0] f);
      exp_t x;
      x.p = p; x.e = e; x.f = f;
      q2.push_back(x);
   endtask

   task automatic push_delayed();
      exp_t x;
      x.p = 1'b1; x.e = 4'd0; x.f = 4'd0;
      q1.push_back(1'b0);
      q3.push_back(x);
   endtask

   // kind: 0 plain, 1 check A/B sequence, 2 start pulse in idx2 settle, 3 reset in idx2 settle
   task automatic sweep(input int exp_lat, input int kind);
      int  n = 0;
      bit  seen = 0;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      if (kind == 1) check("ab_seq_0", {14'd0, A2, B2}, 16'd0);
      while (n < 100 && !seen) begin
         @(posedge clk);
         n++;
         #1;
         if (kind == 1 && n < 12) check($sformatf("ab_seq_%0d", n), {14'd0, A2, B2}, 16'(n / 3));
         if (kind == 2 && n == 6) start = 1'b1;
         if (kind == 2 && n == 7) start = 1'b0;
         if (kind == 3 && n == 7) begin
            rst_n = 1'b0;
            #1 check("reset_mid_sweep", {busy2, done2, pass2, A2, B2, err2, fail2}, 16'd0);
            repeat (3) begin
               @(negedge clk);
               check("no_done_in_reset", {15'd0, done2}, 16'd0);
            end
            rst_n = 1'b1;
            return;
         end
         seen = done2;
      end
      check("done_latency", 16'(n), 16'(exp_lat));
   endtask

   initial begin
      #12;
      check("reset_outputs", {busy2, done2, pass2, A2, B2, err2, fail2}, 16'd0);
      check("reset_outputs_u1u3", {busy1, done1, pass1, busy3, done3, pass3, err3}, 16'd0);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(negedge clk);

      mode = 2'd0; push(1'b1, 4'd0, 4'b0000); push_delayed();
      sweep(12, 1);
      repeat (20) @(posedge clk);
      check("pass_held", {11'd0, pass2, fail2}, {11'd0, 1'b1, 4'b0000});

      mode = 2'd1; push(1'b0, 4'd1, 4'b0001); push_delayed();
`ifdef DEMORGAN_CHK_HALT_EN
      sweep(3, 0);
`else
      sweep(12, 0);
`endif
      repeat (20) @(posedge clk);

      mode = 2'd2; push_delayed();
`ifdef DEMORGAN_CHK_HALT_EN
      push(1'b0, 4'd1, 4'b0010);
      sweep(6, 0);
`else
      push(1'b0, 4'd2, 4'b0110);
      sweep(12, 0);
`endif
      repeat (20) @(posedge clk);

      mode = 2'd0; push(1'b1, 4'd0, 4'b0000); push_delayed();
`ifdef DEMORGAN_CHK_HALT_EN
      q1.push_back(1'b0);
`endif
      sweep(12, 2);
      repeat (20) @(posedge clk);

`ifdef DEMORGAN_CHK_HALT_EN
      q1.push_back(1'b0);
`endif
      sweep(0, 3);
      repeat (10) @(posedge clk);
      push(1'b1, 4'd0, 4'b0000); push_delayed();
      sweep(12, 0);
      repeat (20) @(posedge clk);

      mode = 2'd3; push_delayed();
`ifdef DEMORGAN_CHK_HALT_EN
      push(1'b0, 4'd1, 4'b0001);
      sweep(3, 0);
`else
      push(1'b0, 4'd2, 4'b0011);
      sweep(12, 0);
`endif
      repeat (25) @(posedge clk);

      check("q2_drained", 16'(q2.size()), 16'd0);
      check("q1_drained", 16'(q1.size()), 16'd0);
      check("q3_drained", 16'(q3.size()), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
